input_port: RTL and testbench

//  Upstream I/O stage feeding the CPU's IN instruction: owns the CPU 'in' and 'control' inputs and watches its 'status' request.

---
 rtl/input_port_pkg.sv | 20 ++
 rtl/input_port_if.sv | 25 ++
 rtl/input_port_debouncer.sv | 76 +++++++
 rtl/input_port.sv | 92 +++++++++
 tb/tb_input_port.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/input_port_pkg.sv
// Shared types and constants for the input_port block: debounce FSM encoding and
// default debounce lengths for simulation and board builds.
package input_port_pkg;

  typedef enum logic [1:0] {
    StIdleLo = 2'd0,
    StWaitHi = 2'd1,
    StIdleHi = 2'd2,
    StWaitLo = 2'd3
  } db_state_e;

  localparam int unsigned DebounceCyclesSim   = 16;
  localparam int unsigned DebounceCyclesBoard = 500000;

  // Bits needed to count 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_port_if.sv
// Switch/button entry and CPU IN-handshake signals of input_port.
// The slave side is the port itself; the master side is the board/CPU environment.
interface input_port_if #(
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned CountWidth = 3
);
  logic [DataWidth-1:0]  sw;
  logic                  btn;
  logic                  status;
  logic [DataWidth-1:0]  in_data;
  logic                  control;
  logic [CountWidth-1:0] count;
  logic                  full;
  logic                  overflow;

  modport master (
    output sw, btn, status,
    input  in_data, control, count, full, overflow
  );

  modport slave (
    input  sw, btn, status,
    output in_data, control, count, full, overflow
  );
endinterface

// File: rtl/input_port_debouncer.sv
// Two-flop synchronizer plus debounce FSM; emits a one-cycle pulse when a press
// has been stable for DebounceCycles synchronized samples.
module input_port_debouncer
  import input_port_pkg::*;
#(
  parameter int unsigned DebounceCycles = DebounceCyclesSim
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_pulse_o
);

  localparam int unsigned CntW = cnt_bits(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [1:0]      sync_q;
  logic            in_s;
  db_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign in_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= StIdleLo;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rise_pulse_o = 1'b0;
    unique case (state_q)
      StIdleLo: if (in_s) begin
        state_d = StWaitHi;
        cnt_d   = '0;
      end
      StWaitHi: begin
        if (!in_s) begin
          state_d = StIdleLo;
        end else if (cnt_q == CntLast) begin
          state_d      = StIdleHi;
          rise_pulse_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdleHi: if (!in_s) begin
        state_d = StWaitLo;
        cnt_d   = '0;
      end
      StWaitLo: begin
        // Release is debounced the same way but produces no pulse.
        if (in_s) begin
          state_d = StIdleHi;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleLo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdleLo;
    endcase
  end

  assign level_o = (state_q == StIdleHi) || (state_q == StWaitLo);

endmodule

// File: rtl/input_port.sv
// Switch-entry stage for the CPU IN instruction: debounced presses queue the
// synchronized switch word in a FIFO that is drained one word per CPU request.
module input_port
  import input_port_pkg::*;
#(
  parameter int unsigned DataWidth      = 16,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned DebounceCycles = DebounceCyclesSim
) (
  input logic         clk,
  input logic         rst,
  input_port_if.slave port
);

  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CountW = PtrW + 1;

  logic [DataWidth-1:0] sw_meta_q, sw_sync_q;
  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]    count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 press, btn_level;
  logic                 not_empty, is_full, pop, push;

  input_port_debouncer #(
    .DebounceCycles(DebounceCycles)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .raw_i       (port.btn),
    .level_o     (btn_level),
    .rise_pulse_o(press)
  );

  a_press_level: assert property (@(posedge clk) disable iff (rst) press |=> btn_level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= port.sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == CountW'(FifoDepth));
  assign pop       = port.status & not_empty;
  // A pop in the same cycle frees a slot, so a press while full is still accepted.
  assign push      = press & (~is_full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (press & ~push);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sw_sync_q;
  end

  assign port.in_data  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign port.control  = pop;
  assign port.count    = count_q;
  assign port.full     = is_full;
  assign port.overflow = overflow_q;

endmodule

// File: tb/tb_input_port.sv
// Randomized scoreboard bench for input_port: presses schedule expected pushes,
// a queue model tracks FIFO contents, and a negedge monitor checks every cycle.
module tb_input_port;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DC    = 16;

  typedef struct {
    int unsigned edge_n;
    logic [DW-1:0] val;
  } sched_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_port_if #(.DataWidth(DW), .CountWidth(3)) ifc ();

  input_port #(
    .DataWidth     (DW),
    .FifoDepth     (DEPTH),
    .DebounceCycles(DC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .port(ifc)
  );

  int unsigned   cyc = 0;
  sched_t        sched_q[$];
  logic [DW-1:0] model_q[$];
  bit            model_ovf = 1'b0;
  int            tests = 0;
  int            fails = 0;
  bit            cpu_rand = 1'b0;
  int unsigned   force_edge = 0;
  bit            accepted = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard: compare against the queue model, then advance it to the next edge.
  always @(negedge clk) begin
    bit            pop_e, push_e;
    logic [DW-1:0] v;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      accepted  = 1'b0;
      check("rst_count", 32'(ifc.count), 0);
      check("rst_control", 32'(ifc.control), 0);
      check("rst_in_data", 32'(ifc.in_data), 0);
      check("rst_full", 32'(ifc.full), 0);
      check("rst_overflow", 32'(ifc.overflow), 0);
    end else begin
      pop_e = ifc.status && (model_q.size() != 0);
      check("control", 32'(ifc.control), 32'(pop_e));
      check("count", 32'(ifc.count), model_q.size());
      check("full", 32'(ifc.full), 32'(model_q.size() == DEPTH));
      check("overflow", 32'(ifc.overflow), 32'(model_ovf));
      check("in_data", 32'(ifc.in_data), (model_q.size() != 0) ? 32'(model_q[0]) : 0);
      accepted = pop_e;
      push_e = 1'b0;
      v = '0;
      while (sched_q.size() != 0 && sched_q[0].edge_n <= cyc) void'(sched_q.pop_front());
      if (sched_q.size() != 0 && sched_q[0].edge_n == cyc + 1) begin
        push_e = 1'b1;
        v = sched_q[0].val;
        void'(sched_q.pop_front());
      end
      if (pop_e) void'(model_q.pop_front());
      if (push_e) begin
        if (model_q.size() < DEPTH) model_q.push_back(v);
        else model_ovf = 1'b1;
      end
    end
  end

  // CPU model: requests, holds until served, drops status the cycle after acceptance.
  initial begin
    ifc.status = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || accepted) ifc.status = 1'b0;
      else if (force_edge == cyc + 1) ifc.status = 1'b1;
      else if (!cpu_rand) ifc.status = 1'b0;
      else if (!ifc.status) ifc.status = ($urandom_range(0, 2) == 0);
    end
  end

  // Clean press; a debounced push is due 3+DC edges after the edge preceding the rise.
  task automatic press(input logic [DW-1:0] v, input bit pop_with_push);
    @(posedge clk);
    #1;
    ifc.sw  = v;
    ifc.btn = 1'b1;
    sched_q.push_back('{edge_n: cyc + 3 + DC, val: v});
    if (pop_with_push) force_edge = cyc + 3 + DC;
    repeat (DC + 6) @(posedge clk);
    #1;
    ifc.btn = 1'b0;
    repeat (DC + 6) @(posedge clk);
  endtask

  task automatic bounce_press(input logic [DW-1:0] v);
    int unsigned last_rise;
    @(posedge clk);
    #1;
    ifc.sw = v;
    last_rise = cyc;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) begin
        ifc.btn = ~ifc.btn;
        if (ifc.btn) last_rise = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!ifc.btn) begin
      ifc.btn = 1'b1;
      last_rise = cyc;
    end
    sched_q.push_back('{edge_n: last_rise + 3 + DC, val: v});
    repeat (DC + 6) @(posedge clk);
    #1;
    ifc.btn = 1'b0;
    repeat (DC + 6) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.sw  = '0;
    ifc.btn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-WAIT_HI with two entries queued; the aborted press must not land.
    press(16'h0011, 1'b0);
    press(16'h0022, 1'b0);
    @(posedge clk);
    #1 ifc.btn = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_count", 32'(ifc.count), 0);
    check("async_rst_in_data", 32'(ifc.in_data), 0);
    ifc.btn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (DC + 10) @(posedge clk);

    // Bouncing button yields exactly one push.
    bounce_press(16'h00A5);

    // Handshake: status low holds control low; one request pops the head.
    cpu_rand = 1'b0;
    press(16'h0003, 1'b0);
    press(16'h0007, 1'b0);
    repeat (50) @(posedge clk);
    #1 force_edge = cyc + 2;
    repeat (5) @(posedge clk);
    cpu_rand = 1'b1;
    repeat (30) @(posedge clk);

    // Overflow: fifth press dropped.
    cpu_rand = 1'b0;
    for (int i = 1; i <= 5; i++) press(DW'(i), 1'b0);
    cpu_rand = 1'b1;
    repeat (40) @(posedge clk);

    // Clear the sticky overflow before the simultaneous push/pop case.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cpu_rand = 1'b0;
    for (int i = 1; i <= 4; i++) press(DW'(i), 1'b0);
    press(16'h0009, 1'b1);
    cpu_rand = 1'b1;
    repeat (40) @(posedge clk);

    // Wrap: ten interleaved push/pop rounds.
    for (int i = 10; i <= 19; i++) press(DW'(i), 1'b0);
    repeat (20) @(posedge clk);

    // Random presses with random request activity.
    for (int i = 0; i < 12; i++) begin
      cpu_rand = ($urandom_range(0, 1) == 1);
      press(DW'($urandom), 1'b0);
    end
    cpu_rand = 1'b1;
    repeat (60) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
